// File: rtl/alu32_two_pass_ctrl_pkg.sv
// Shared op codes, FSM states and decoded-op bundle for the two-pass 32-bit ALU sequencer.
// Pure definitions: no latency, no backpressure.
package alu32_two_pass_ctrl_pkg;

  localparam int HALF_W_DEF = 16;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic       legal;
    logic       is_arith;
    logic       is_sub;
    logic       is_slt;
    logic [2:0] slice_op;
  } dec_t;

endpackage

// File: rtl/alu32_two_pass_ctrl_if.sv
// Issue-side valid/ready request/result bus plus the half-width ALU slice hookup.
// slave = the sequencer; master = issue logic, consumer and ALU slice.
interface alu32_two_pass_ctrl_if #(parameter int HALF_W = 16);

  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [2*HALF_W-1:0]   in_a;
  logic [2*HALF_W-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*HALF_W-1:0]   out_result;
  logic                  out_cout;
  logic                  out_ovf;
  logic                  out_zero;
  logic                  out_err;
  logic [HALF_W-1:0]     alu_a;
  logic [HALF_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic                  alu_cin;
  logic                  alu_less;
  logic [HALF_W-1:0]     alu_result;
  logic                  alu_cout;
  logic                  alu_set;
  logic                  alu_ovf;
  logic                  alu_zero;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    input  alu_result, alu_cout, alu_set, alu_ovf, alu_zero,
    output in_ready, out_valid, out_result, out_cout, out_ovf, out_zero, out_err,
    output alu_a, alu_b, alu_op, alu_cin, alu_less
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    output alu_result, alu_cout, alu_set, alu_ovf, alu_zero,
    input  in_ready, out_valid, out_result, out_cout, out_ovf, out_zero, out_err,
    input  alu_a, alu_b, alu_op, alu_cin, alu_less
  );

endinterface

// File: rtl/alu32_two_pass_ctrl_decode.sv
// Combinational op decoder: legality, carry usage and the op code issued to the slice.
// Zero latency, no backpressure.
module alu_op_decode
  import alu32_two_pass_ctrl_pkg::*;
(
  input  logic [2:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_AND: begin
        dec_o.legal    = 1'b1;
        dec_o.slice_op = OP_AND;
      end
      OP_OR: begin
        dec_o.legal    = 1'b1;
        dec_o.slice_op = OP_OR;
      end
      OP_ADD: begin
        dec_o.legal    = 1'b1;
        dec_o.is_arith = 1'b1;
        dec_o.slice_op = OP_ADD;
      end
      OP_SUB: begin
        dec_o.legal    = 1'b1;
        dec_o.is_arith = 1'b1;
        dec_o.is_sub   = 1'b1;
        dec_o.slice_op = OP_SUB;
      end
      // SLT runs as a full subtract; the compare bit is formed from the high-pass flags
      OP_SLT: begin
        dec_o.legal    = 1'b1;
        dec_o.is_arith = 1'b1;
        dec_o.is_sub   = 1'b1;
        dec_o.is_slt   = 1'b1;
        dec_o.slice_op = OP_SUB;
      end
      default: dec_o = '0;
    endcase
  end

endmodule

// File: rtl/alu32_two_pass_ctrl.sv
// Runs 2*HALF_W-bit ops on one HALF_W slice in two passes; accept -> out_valid three edges later.
// in_ready only in IDLE; the result is held in DONE until out_ready.
module alu32_two_pass_ctrl
  import alu32_two_pass_ctrl_pkg::*;
#(
  parameter int HALF_W = HALF_W_DEF
)
(
  input  logic                 clk,
  input  logic                 reset,
  alu32_two_pass_ctrl_if.slave bus
);

  localparam int W = 2 * HALF_W;

  state_e              state_q;
  logic                is_arith_q;
  logic                is_slt_q;
  logic [HALF_W-1:0]   a_hi_q;
  logic [HALF_W-1:0]   b_hi_q;
  logic [HALF_W-1:0]   res_lo_q;
  logic                zlo_q;

  logic [HALF_W-1:0]   alu_a_q;
  logic [HALF_W-1:0]   alu_b_q;
  logic [2:0]          alu_op_q;
  logic                alu_cin_q;

  logic                out_valid_q;
  logic [W-1:0]        out_result_q;
  logic                out_cout_q;
  logic                out_ovf_q;
  logic                out_zero_q;
  logic                out_err_q;

  logic [W-1:0]        out_result_d;
  logic                out_cout_d;
  logic                out_ovf_d;
  logic                out_zero_d;

  dec_t                dec;

  alu_op_decode u_dec (
    .op_i  (bus.in_op),
    .dec_o (dec)
  );

  // Final result assembly from the high-pass slice outputs and the captured low pass
  always_comb begin
    out_result_d = {bus.alu_result, res_lo_q};
    out_cout_d   = is_arith_q & ~is_slt_q & bus.alu_cout;
    out_ovf_d    = is_arith_q & ~is_slt_q & bus.alu_ovf;
    out_zero_d   = zlo_q & bus.alu_zero;
    if (is_slt_q) begin
      out_result_d = {{(W-1){1'b0}}, bus.alu_set};
      out_zero_d   = ~bus.alu_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_arith_q   <= 1'b0;
      is_slt_q     <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      res_lo_q     <= '0;
      zlo_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_cin_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_zero_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            is_arith_q <= dec.is_arith;
            is_slt_q   <= dec.is_slt;
            a_hi_q     <= bus.in_a[W-1:HALF_W];
            b_hi_q     <= bus.in_b[W-1:HALF_W];
            if (dec.legal) begin
              state_q   <= ST_LO;
              alu_a_q   <= bus.in_a[HALF_W-1:0];
              alu_b_q   <= bus.in_b[HALF_W-1:0];
              alu_op_q  <= dec.slice_op;
              alu_cin_q <= dec.is_sub;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
            end
          end
        end
        ST_LO: begin
          state_q   <= ST_HI;
          res_lo_q  <= bus.alu_result;
          zlo_q     <= bus.alu_zero;
          alu_a_q   <= a_hi_q;
          alu_b_q   <= b_hi_q;
          alu_cin_q <= is_arith_q & bus.alu_cout;
        end
        ST_HI: begin
          state_q      <= ST_DONE;
          out_valid_q  <= 1'b1;
          out_result_q <= out_result_d;
          out_cout_q   <= out_cout_d;
          out_ovf_q    <= out_ovf_d;
          out_zero_q   <= out_zero_d;
          out_err_q    <= 1'b0;
          alu_a_q      <= '0;
          alu_b_q      <= '0;
          alu_op_q     <= '0;
          alu_cin_q    <= 1'b0;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_cout_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
            out_err_q    <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_cout   = out_cout_q;
  assign bus.out_ovf    = out_ovf_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_err    = out_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_cin    = alu_cin_q;
  assign bus.alu_less   = 1'b0;

endmodule

// File: tb/tb_alu32_two_pass_ctrl.sv
// Bench for alu32_two_pass_ctrl: behavioural slice, 32-bit reference model, directed and random ops.
module tb_alu32_two_pass_ctrl;

  localparam int HW = 16;

  typedef struct {
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];

  alu32_two_pass_ctrl_if #(.HALF_W(HW)) bus_if ();

  alu32_two_pass_ctrl #(.HALF_W(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational model of the existing 16-bit ALU slice
  logic [16:0] sl_sum;
  logic [15:0] sl_bb;
  always_comb begin
    sl_sum = '0;
    sl_bb  = bus_if.alu_b;
    bus_if.alu_result = '0;
    bus_if.alu_cout   = 1'b0;
    bus_if.alu_ovf    = 1'b0;
    case (bus_if.alu_op)
      3'b000: bus_if.alu_result = bus_if.alu_a & bus_if.alu_b;
      3'b001: bus_if.alu_result = bus_if.alu_a | bus_if.alu_b;
      3'b010, 3'b110: begin
        if (bus_if.alu_op == 3'b110) sl_bb = ~bus_if.alu_b;
        sl_sum = {1'b0, bus_if.alu_a} + {1'b0, sl_bb} + {16'd0, bus_if.alu_cin};
        bus_if.alu_result = sl_sum[15:0];
        bus_if.alu_cout   = sl_sum[16];
        bus_if.alu_ovf    = (bus_if.alu_a[15] == sl_bb[15]) && (sl_sum[15] != bus_if.alu_a[15]);
      end
      default: bus_if.alu_result = '0;
    endcase
    bus_if.alu_set  = bus_if.alu_result[15] ^ bus_if.alu_ovf;
    bus_if.alu_zero = (bus_if.alu_result == 16'd0);
  end

  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [32:0] s;
    r = '{result: 32'd0, cout: 1'b0, ovf: 1'b0, zero: 1'b0, err: 1'b0};
    case (op)
      3'b000: r.result = a & b;
      3'b001: r.result = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r.result = s[31:0];
        r.cout   = s[32];
        r.ovf    = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r.result = s[31:0];
        r.cout   = s[32];
        r.ovf    = (a[31] != b[31]) && (s[31] != a[31]);
      end
      3'b111: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r.err = 1'b1;
    endcase
    r.zero = !r.err && (r.result == 32'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle a result is presented it must match the oldest accepted op
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      chk("alu_less", {31'd0, bus_if.alu_less}, 32'd0);
      if (bus_if.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          chk("result", bus_if.out_result, exp_q[0].result);
          chk("cout", {31'd0, bus_if.out_cout}, {31'd0, exp_q[0].cout});
          chk("ovf", {31'd0, bus_if.out_ovf}, {31'd0, exp_q[0].ovf});
          chk("zero", {31'd0, bus_if.out_zero}, {31'd0, exp_q[0].zero});
          chk("err", {31'd0, bus_if.out_err}, {31'd0, exp_q[0].err});
          chk("done_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
          if (bus_if.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus_if.in_valid && bus_if.in_ready)
        exp_q.push_back(ref_op(bus_if.in_op, bus_if.in_a, bus_if.in_b));
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] res, output logic [3:0] flg,
                       output logic hi_cin);
    exp_t        e;
    int          lat;
    int          cnt;
    logic        ok;
    logic        exp_lo_cin;
    logic        exp_hi_cin;
    logic [16:0] lo_sum;
    e = ref_op(op, a, b);
    exp_lo_cin = (op == 3'b110) || (op == 3'b111);
    if (op == 3'b010)      lo_sum = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    else if (exp_lo_cin)   lo_sum = {1'b0, a[15:0]} + {1'b0, ~b[15:0]} + 17'd1;
    else                   lo_sum = '0;
    exp_hi_cin = lo_sum[16];
    res = '0; flg = '0; hi_cin = 1'b0;
    bus_if.in_op = op; bus_if.in_a = a; bus_if.in_b = b; bus_if.in_valid = 1'b1;
    cnt = 0; ok = 1'b0;
    while (!ok && cnt < 20) begin
      @(negedge clk);
      ok = bus_if.in_ready;
      @(posedge clk); #1;
      cnt++;
    end
    chk("accept", {31'd0, ok}, 32'd1);
    // Keep requesting with junk while busy: it must neither be accepted nor disturb the op
    bus_if.in_op = 3'($urandom_range(0, 7));
    bus_if.in_a  = $urandom;
    bus_if.in_b  = $urandom;
    lat = 1;
    while (ok && lat < 10) begin
      @(negedge clk);
      if (bus_if.out_valid) break;
      if (lat == 1) begin
        chk("lo_cin", {31'd0, bus_if.alu_cin}, {31'd0, exp_lo_cin});
        chk("lo_a", {16'd0, bus_if.alu_a}, {16'd0, a[15:0]});
      end
      if (lat == 2) begin
        hi_cin = bus_if.alu_cin;
        chk("hi_cin", {31'd0, bus_if.alu_cin}, {31'd0, exp_hi_cin});
        chk("hi_b", {16'd0, bus_if.alu_b}, {16'd0, b[31:16]});
      end
      @(posedge clk); #1;
      lat++;
    end
    bus_if.in_valid = 1'b0;
    chk("latency", lat, e.err ? 32'd1 : 32'd3);
    res = bus_if.out_result;
    flg = {bus_if.out_cout, bus_if.out_ovf, bus_if.out_zero, bus_if.out_err};
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    chk("released", {31'd0, bus_if.out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [7];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_FFFF, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 6)];
    return $urandom;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    logic        hc;
    logic [2:0]  legal_ops [5];
    logic [2:0]  op;
    int          seen;
    legal_ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
    n_chk = 0; n_fail = 0;
    reset = 1'b1;
    bus_if.in_valid = 1'b0; bus_if.in_op = 3'b000; bus_if.in_a = '0; bus_if.in_b = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("rst_result", bus_if.out_result, 32'd0);
    chk("rst_err", {31'd0, bus_if.out_err}, 32'd0);
    chk("rst_alu_a", {16'd0, bus_if.alu_a}, 32'd0);
    @(posedge clk); #1;

    do_op(3'b010, 32'h0000_FFFF, 32'h0000_0001, 0, r, f, hc);
    chk("add_carry_res", r, 32'h0001_0000);
    chk("add_carry_flags", {28'd0, f}, 32'h0);
    chk("add_carry_hi_cin", {31'd0, hc}, 32'd1);
    do_op(3'b110, 32'h8000_0000, 32'h0000_0001, 1, r, f, hc);
    chk("sub_ovf_res", r, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", {31'd0, f[2]}, 32'd1);
    do_op(3'b110, 32'd5, 32'd5, 0, r, f, hc);
    chk("sub_zero_res", r, 32'd0);
    chk("sub_zero_flags", {28'd0, f}, 32'b1010);
    do_op(3'b111, 32'hFFFF_FFFF, 32'd1, 0, r, f, hc);
    chk("slt_neg_pos", r, 32'd1);
    do_op(3'b111, 32'd1, 32'hFFFF_FFFF, 0, r, f, hc);
    chk("slt_pos_neg", r, 32'd0);
    chk("slt_pos_neg_zero", {28'd0, f}, 32'b0010);
    do_op(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 2, r, f, hc);
    chk("slt_ovf_case", r, 32'd1);
    chk("slt_ovf_flags", {28'd0, f}, 32'b0000);
    do_op(3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, r, f, hc);
    chk("and_res", r, 32'h00F0_00F0);
    do_op(3'b001, 32'd0, 32'd0, 0, r, f, hc);
    chk("or_zero_res", r, 32'd0);
    chk("or_zero_flags", {28'd0, f}, 32'b0010);
    do_op(3'b010, 32'h1234_5678, 32'h1111_1111, 5, r, f, hc);
    chk("add_held_res", r, 32'h2345_6789);
    do_op(3'b011, 32'hDEAD_BEEF, 32'h1, 0, r, f, hc);
    chk("illegal_res", r, 32'd0);
    chk("illegal_flags", {28'd0, f}, 32'b0001);

    // Reset landing in the high pass discards the op
    bus_if.in_op = 3'b010; bus_if.in_a = 32'd7; bus_if.in_b = 32'd9; bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst_hi_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("rst_hi_result", bus_if.out_result, 32'd0);
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus_if.out_valid) seen++;
    end
    chk("rst_hi_no_pulse", seen, 32'd0);
    do_op(3'b010, 32'd1, 32'd2, 0, r, f, hc);
    chk("post_rst_add", r, 32'd3);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 3'($urandom_range(3, 5));
      else op = legal_ops[$urandom_range(0, 4)];
      do_op(op, pick_operand(), pick_operand(), $urandom_range(0, 3), r, f, hc);
    end
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
